sccb_target: RTL and testbench

- Synthesizable SCCB target (camera-side responder) for OV7670-style 3-phase write and 2-phase write / 2-phase read transactions.
- Oversamples the bus lines on the system clock and holds a small internal register file.
- Used as an on-FPGA camera model, so the existing SCCB initiator and config sequencer can run closed-loop in simulation and on hardware.
- Drives SIOD open-drain through an output-enable; the top level owns the tristate.

---
 rtl/sccb_target.sv | 189 ++++++++++++++++++
 tb/tb_sccb_target.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// SCCB target (camera-side responder): oversampled bus decode, 3-phase write,
// 2-phase write/read, small register file with PID/VER read-only IDs.
module sccb_target #(
    parameter logic [6:0]  DEV_ID    = 7'h21,
    parameter int unsigned REG_COUNT = 32,
    parameter logic [7:0]  PID_VAL   = 8'h76,
    parameter logic [7:0]  VER_VAL   = 8'h73,
    parameter bit          DRIVE_ACK = 1'b1
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       soft_rst,
    output logic       busy,
    output logic       err
);
    localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ID        = 3'd1;
    localparam logic [2:0] S_SUB       = 3'd2;
    localparam logic [2:0] S_WDATA     = 3'd3;
    localparam logic [2:0] S_RDATA     = 3'd4;
    localparam logic [2:0] S_RNA       = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    // [0],[1] synchronizer, [2] history for edge detection
    logic [2:0] sioc_q, siod_q;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rd_ptr_q, rd_ptr_d;
    logic       oe_q, oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       soft_rst_q, soft_rst_d;
    logic       err_q, err_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [REG_COUNT];
    logic [7:0] regs_d [REG_COUNT];

    logic sioc_s, siod_s, sioc_rise, sioc_fall, start_det, stop_det;
    logic [7:0] rd_val;
    logic       ptr_rw;

    assign sioc_s    = sioc_q[1];
    assign siod_s    = siod_q[1];
    assign sioc_rise = sioc_s & ~sioc_q[2];
    assign sioc_fall = ~sioc_s & sioc_q[2];
    assign start_det = sioc_s & sioc_q[2] & siod_q[2] & ~siod_s;
    assign stop_det  = sioc_s & sioc_q[2] & ~siod_q[2] & siod_s;

    assign ptr_rw = (32'(rd_ptr_q) < REG_COUNT) && (rd_ptr_q != 8'h0A) && (rd_ptr_q != 8'h0B);

    always_comb begin
        rd_val = 8'h00;
        if (rd_ptr_q == 8'h0A)                rd_val = PID_VAL;
        else if (rd_ptr_q == 8'h0B)           rd_val = VER_VAL;
        else if (32'(rd_ptr_q) < REG_COUNT)   rd_val = regs_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rd_ptr_d    = rd_ptr_q;
        oe_d        = oe_q;
        regs_d      = regs_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = 1'b0;
        soft_rst_d  = 1'b0;
        err_d       = 1'b0;
        if (start_det) begin
            state_d   = S_ID;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            // The STOP's own sioc high samples one bit, so WDATA with <=1 bit is a 2-phase write.
            if ((state_q == S_ID) || (state_q == S_SUB) || (state_q == S_RDATA) ||
                ((state_q == S_WDATA) && (bit_cnt_q > 4'd1)))
                err_d = 1'b1;
        end else if (sioc_rise) begin
            case (state_q)
                S_ID, S_SUB, S_WDATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], siod_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if ((state_q == S_ID) && (bit_cnt_q == 4'd7) && (shreg_d[7:1] != DEV_ID))
                            state_d = S_WAIT_STOP;
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (state_q == S_ID) begin
                            if (shreg_q[0]) begin
                                state_d = S_RDATA;
                                shreg_d = rd_val;
                            end else begin
                                state_d = S_SUB;
                            end
                        end else if (state_q == S_SUB) begin
                            rd_ptr_d = shreg_q;
                            state_d  = S_WDATA;
                        end else begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = rd_ptr_q;
                            wr_data_d   = shreg_q;
                            if (ptr_rw) regs_d[rd_ptr_q[AW-1:0]] = shreg_q;
                            if ((rd_ptr_q == 8'h12) && shreg_q[7]) begin
                                soft_rst_d = 1'b1;
                                for (int unsigned i = 0; i < REG_COUNT; i++) regs_d[i] = 8'h00;
                            end
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], siod_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_RNA:   state_d = S_WAIT_STOP;
                default: ;
            endcase
        end else if (sioc_fall) begin
            case (state_q)
                S_ID, S_SUB, S_WDATA: oe_d = (bit_cnt_q == 4'd8) && DRIVE_ACK;
                S_RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        state_d = S_RNA;
                    end else begin
                        oe_d = ~shreg_q[7];
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sioc_q      <= 3'b111;
            siod_q      <= 3'b111;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'h00;
            rd_ptr_q    <= 8'h00;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            soft_rst_q  <= 1'b0;
            err_q       <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
        end else begin
            sioc_q      <= {sioc_q[1:0], sioc_in};
            siod_q      <= {siod_q[1:0], siod_in};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rd_ptr_q    <= rd_ptr_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            soft_rst_q  <= soft_rst_d;
            err_q       <= err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign siod_oe   = oe_q;
    assign wr_strobe = wr_strobe_q;
    assign soft_rst  = soft_rst_q;
    assign err       = err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: open-drain bus master driving directed and randomized
// transactions, checked against a register-map model of the camera.
module tb_sccb_target;
    localparam int H = 8;
    localparam int Q = 4;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       sioc = 1'b1;
    logic       m_sda = 1'b1;
    logic       siod_bus;
    logic       siod_oe, wr_strobe, soft_rst, busy, err;
    logic [7:0] wr_addr, wr_data;

    assign siod_bus = m_sda & ~siod_oe;
    always #5 PCLK = ~PCLK;

    sccb_target dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .sioc_in(sioc), .siod_in(siod_bus),
        .siod_oe(siod_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .soft_rst(soft_rst), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int n_strobe = 0, n_err = 0, n_soft = 0, n_soft_co = 0;
    logic [7:0] last_addr = 8'h00, last_data = 8'h00;
    logic oe_seen = 1'b0;

    always @(negedge PCLK) begin
        if (wr_strobe) begin
            n_strobe++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (err) n_err++;
        if (soft_rst) n_soft++;
        if (soft_rst && wr_strobe) n_soft_co++;
        if (siod_oe) oe_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Camera register map model
    logic [7:0] mregs [32];

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a == 8'h0A) return 8'h76;
        if (a == 8'h0B) return 8'h73;
        if (a >= 8'd32) return 8'h00;
        return mregs[a[4:0]];
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (a < 8'd32 && a != 8'h0A && a != 8'h0B) mregs[a[4:0]] = d;
        if (a == 8'h12 && d[7]) for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic clk_bit(input logic b, output logic s, output logic oe_hi);
        wait_cyc(Q); m_sda = b;
        wait_cyc(Q); sioc = 1'b1;
        wait_cyc(H); s = siod_bus; oe_hi = siod_oe;
        sioc = 1'b0;
    endtask

    task automatic start_c();
        wait_cyc(Q); m_sda = 1'b1;
        wait_cyc(Q); sioc = 1'b1;
        wait_cyc(H); m_sda = 1'b0;
        wait_cyc(H); sioc = 1'b0;
    endtask

    task automatic stop_c(output int lat);
        wait_cyc(Q); m_sda = 1'b0;
        wait_cyc(Q); sioc = 1'b1;
        wait_cyc(H); m_sda = 1'b1;
        lat = 99;
        for (int i = 1; i <= H; i++) begin
            wait_cyc(1);
            if (lat == 99 && !busy) lat = i;
        end
    endtask

    // ack = target pulled the bus low with siod_oe up at the end of the 9th bit
    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s, o);
        clk_bit(1'b1, s, o);
        ack = o && !s;
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic s, o;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s, o);
            v[i] = s;
        end
        clk_bit(1'b1, s, o);
    endtask

    task automatic do_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] d,
                            output int acks, output int lat);
        logic a;
        acks = 0;
        start_c();
        send_byte(id, a);  acks += int'(a);
        send_byte(sub, a); acks += int'(a);
        send_byte(d, a);   acks += int'(a);
        stop_c(lat);
    endtask

    task automatic do_read(input logic [7:0] sub, output logic [7:0] v, output int acks);
        logic a;
        int lat;
        acks = 0;
        start_c();
        send_byte(8'h42, a); acks += int'(a);
        send_byte(sub, a);   acks += int'(a);
        stop_c(lat);
        start_c();
        send_byte(8'h43, a); acks += int'(a);
        read_byte(v);
        stop_c(lat);
    endtask

    initial begin
        int acks, lat, s0, e0, k0, c0;
        logic [7:0] v;
        logic s, o, a;
        for (int i = 0; i < 32; i++) mregs[i] = 8'h00;

        wait_cyc(3);
        chk("rst_oe", siod_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_err", err, 0);
        chk("rst_soft", soft_rst, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        PRESETN = 1'b1;
        wait_cyc(6);

        // 3-phase write
        s0 = n_strobe; e0 = n_err;
        do_write(8'h42, 8'h05, 8'hAA, acks, lat);
        m_write(8'h05, 8'hAA);
        chk("wr_acks", acks, 3);
        chk("wr_strobes", n_strobe - s0, 1);
        chk("wr_addr", last_addr, 8'h05);
        chk("wr_data", last_data, 8'hAA);
        chk("wr_busy_lat", (lat >= 1 && lat <= 3), 1);
        chk("wr_no_err", n_err - e0, 0);

        // Reads of PID and written register
        s0 = n_strobe;
        do_read(8'h0A, v, acks);
        chk("rd_pid", v, 8'h76);
        chk("rd_pid_acks", acks, 3);
        do_read(8'h05, v, acks);
        chk("rd_05", v, m_read(8'h05));
        chk("rd_no_strobe", n_strobe - s0, 0);
        do_read(8'h0B, v, acks);
        chk("rd_ver", v, 8'h73);
        do_read(8'h40, v, acks);
        chk("rd_oor", v, 8'h00);

        // Foreign device address
        wait_cyc(2); oe_seen = 1'b0; s0 = n_strobe;
        do_write(8'h60, 8'h05, 8'h55, acks, lat);
        chk("foreign_acks", acks, 0);
        chk("foreign_oe", oe_seen, 0);
        chk("foreign_strobe", n_strobe - s0, 0);
        do_read(8'h05, v, acks);
        chk("foreign_reg", v, m_read(8'h05));

        // Read-only write attempt
        do_write(8'h42, 8'h0A, 8'h11, acks, lat);
        m_write(8'h0A, 8'h11);
        do_read(8'h0A, v, acks);
        chk("ro_pid", v, 8'h76);

        // Soft reset
        s0 = n_strobe; k0 = n_soft; c0 = n_soft_co;
        do_write(8'h42, 8'h12, 8'h80, acks, lat);
        m_write(8'h12, 8'h80);
        chk("srst_strobe", n_strobe - s0, 1);
        chk("srst_pulse", n_soft - k0, 1);
        chk("srst_same_cycle", n_soft_co - c0, 1);
        do_read(8'h05, v, acks);
        chk("srst_05", v, 8'h00);
        do_read(8'h12, v, acks);
        chk("srst_12", v, 8'h00);
        do_read(8'h0A, v, acks);
        chk("srst_pid", v, 8'h76);

        // STOP after 4 bits of WDATA
        do_write(8'h42, 8'h05, 8'h3C, acks, lat);
        m_write(8'h05, 8'h3C);
        s0 = n_strobe; e0 = n_err;
        start_c();
        send_byte(8'h42, a);
        send_byte(8'h05, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s, o);
        stop_c(lat);
        chk("abort_err", n_err - e0, 1);
        chk("abort_strobe", n_strobe - s0, 0);
        chk("abort_idle", busy, 0);
        do_read(8'h05, v, acks);
        chk("abort_reg", v, m_read(8'h05));

        // Repeated START mid-SUB then valid write
        s0 = n_strobe; e0 = n_err;
        start_c();
        send_byte(8'h42, a);
        for (int i = 0; i < 3; i++) clk_bit(1'b0, s, o);
        start_c();
        send_byte(8'h42, a);
        send_byte(8'h07, a);
        send_byte(8'h5A, a);
        stop_c(lat);
        m_write(8'h07, 8'h5A);
        chk("rs_strobe", n_strobe - s0, 1);
        chk("rs_addr", last_addr, 8'h07);
        chk("rs_data", last_data, 8'h5A);
        chk("rs_err", n_err - e0, 0);

        // Reset while driving bit 3 of PID (0x76 -> bit3 = 0, target pulls low)
        start_c();
        send_byte(8'h42, a);
        send_byte(8'h0A, a);
        stop_c(lat);
        start_c();
        send_byte(8'h43, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s, o);
        wait_cyc(Q + 2);
        chk("mid_rd_oe", siod_oe, 1);
        @(posedge PCLK); #1 PRESETN = 1'b0;
        #1;
        chk("arst_oe", siod_oe, 0);
        chk("arst_busy", busy, 0);
        sioc = 1'b1; m_sda = 1'b1;
        wait_cyc(4);
        PRESETN = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
        wait_cyc(6);
        do_read(8'h07, v, acks);
        chk("arst_regs", v, 8'h00);
        do_write(8'h42, 8'h09, 8'hC3, acks, lat);
        m_write(8'h09, 8'hC3);
        chk("arst_wr_acks", acks, 3);
        do_read(8'h09, v, acks);
        chk("arst_rd", v, 8'hC3);

        // Randomized traffic against the register-map model
        for (int r = 0; r < 22; r++) begin
            logic [7:0] ad, dd;
            ad = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) ad = 8'h12;
            dd = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                s0 = n_strobe;
                do_write(8'h42, ad, dd, acks, lat);
                m_write(ad, dd);
                chk("rnd_wr_strobe", n_strobe - s0, 1);
                chk("rnd_wr_pair", {last_addr, last_data}, {ad, dd});
            end else begin
                do_read(ad, v, acks);
                chk("rnd_rd", v, m_read(ad));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
